// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Holds the NOP encoding, the default reset vector and the fetch FSM state type.
package cpu_pkg;

  localparam logic [15:0] NOP               = 16'h0000;
  localparam logic [15:0] DEFAULT_RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_WAIT
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and instruction memory (slave).
// rdata is valid in the same cycle that ready accepts a request.
interface fetch_stage_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular buffer with a top pointer and an occupancy count.
// Pushing onto a full stack silently overwrites the oldest entry; popping an empty stack is ignored.
module ret_addr_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [15:0] push_addr_i,
  input  logic        pop_i,
  output logic [15:0] top_o,
  output logic        empty_o
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   top_q, top_d;
  logic          wrEn;
  logic [PW-1:0] wrIdx;

  // top_q mirrors mem_q[ptr_q] (or zero when empty) so the output comes straight from a flop.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    top_d = top_q;
    wrEn  = 1'b0;
    wrIdx = ptr_q;
    if (push_i && pop_i && (cnt_q != '0)) begin
      wrEn  = 1'b1;
      top_d = push_addr_i;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      wrEn  = 1'b1;
      wrIdx = ptr_d;
      top_d = push_addr_i;
      if (cnt_q != FULL) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
      top_d = (cnt_d == '0) ? 16'h0000 : mem_q[ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      top_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wrEn) mem_q[wrIdx] <= push_addr_i;
  end

  assign top_o   = top_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and imem valid/ready requester.
// Define FETCH_RAS_EN to build the return-address stack; otherwise ras_top_o = 0 and ras_empty_o = 1.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter int          WAIT_MAX  = 15,
  parameter int          RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic [15:0]   nxt_pc_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic [15:0]   if_pc_o,
  output logic [15:0]   id_pc_o,
  output logic [15:0]   id_instr_o,
  output logic          id_valid_o,
  output logic          fetch_wait_o,
  output logic          imem_timeout_o,
  input  logic          ras_push_i,
  input  logic [15:0]   ras_push_addr_i,
  input  logic          ras_pop_i,
  output logic [15:0]   ras_top_o,
  output logic          ras_empty_o
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  fetch_state_e  state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   idPc_q, idPc_d;
  logic [15:0]   idInstr_q, idInstr_d;
  logic          idValid_q, idValid_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          timeout_q, timeout_d;
  logic          req;

  // Priority inside RUN/WAIT: flush, then stall, then fire, then a missed request.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idPc_d    = idPc_q;
    idInstr_d = idInstr_q;
    idValid_d = idValid_q;
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    req       = 1'b0;
    case (state_q)
      FS_BOOT: state_d = FS_RUN;
      default: begin
        req = !stall_i || flush_i;
        if (flush_i) begin
          idValid_d = 1'b0;
          idInstr_d = NOP;
          pc_d      = nxt_pc_i;
          state_d   = FS_RUN;
          waitCnt_d = '0;
        end else if (stall_i) begin
          state_d = state_q;
        end else if (imem.imem_ready) begin
          idInstr_d = imem.imem_rdata;
          idPc_d    = pc_q;
          idValid_d = 1'b1;
          pc_d      = nxt_pc_i;
          state_d   = FS_RUN;
          waitCnt_d = '0;
        end else begin
          idValid_d = 1'b0;
          idInstr_d = NOP;
          state_d   = FS_WAIT;
          if (waitCnt_q != WAIT_LIM) waitCnt_d = waitCnt_q + CW'(1);
        end
      end
    endcase
    if (waitCnt_d == WAIT_LIM) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FS_BOOT;
      pc_q      <= RESET_VEC;
      idPc_q    <= '0;
      idInstr_q <= NOP;
      idValid_q <= 1'b0;
      waitCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idPc_q    <= idPc_d;
      idInstr_q <= idInstr_d;
      idValid_q <= idValid_d;
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem.imem_req   = req;
  assign imem.imem_addr  = pc_q;
  assign if_pc_o         = pc_q;
  assign id_pc_o         = idPc_q;
  assign id_instr_o      = idInstr_q;
  assign id_valid_o      = idValid_q;
  assign fetch_wait_o    = (state_q == FS_WAIT);
  assign imem_timeout_o  = timeout_q;

`ifdef FETCH_RAS_EN
  ret_addr_stack #(
    .DEPTH(RAS_DEPTH)
  ) uRas (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (ras_push_i),
    .push_addr_i(ras_push_addr_i),
    .pop_i      (ras_pop_i),
    .top_o      (ras_top_o),
    .empty_o    (ras_empty_o)
  );
`else
  logic unusedRas;
  assign unusedRas   = ^{ras_push_i, ras_pop_i, ras_push_addr_i} ^ (RAS_DEPTH > 0);
  assign ras_top_o   = '0;
  assign ras_empty_o = 1'b1;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue/counter reference model checked every cycle,
// plus hand-computed literal checkpoints. Define FETCH_RAS_EN to exercise the return-address stack.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int          WAIT_MAX  = 15;
  localparam int          RAS_DEPTH = 4;
  localparam logic [15:0] RESET_VEC = 16'h0000;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hC3A0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, stall, flush, ready, rasPush, rasPop;
  logic [15:0] nxtPc, rasPushAddr;
  logic [15:0] ifPc, idPc, idInstr, rasTop;
  logic        idValid, fetchWait, imemTimeout, rasEmpty;

  fetch_stage_if imemBus();
  assign imemBus.imem_ready = ready;
  assign imemBus.imem_rdata = memWord(imemBus.imem_addr);

  fetch_stage #(
    .RESET_VEC(RESET_VEC),
    .WAIT_MAX (WAIT_MAX),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rstN),
    .imem           (imemBus),
    .nxt_pc_i       (nxtPc),
    .stall_i        (stall),
    .flush_i        (flush),
    .if_pc_o        (ifPc),
    .id_pc_o        (idPc),
    .id_instr_o     (idInstr),
    .id_valid_o     (idValid),
    .fetch_wait_o   (fetchWait),
    .imem_timeout_o (imemTimeout),
    .ras_push_i     (rasPush),
    .ras_push_addr_i(rasPushAddr),
    .ras_pop_i      (rasPop),
    .ras_top_o      (rasTop),
    .ras_empty_o    (rasEmpty)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model state, written only from the spec's rules
  bit          mBoot;
  logic [15:0] mPc, mIdPc, mIdInstr;
  bit          mIdValid, mWaiting, mTimeout;
  int          mMiss;
  logic [15:0] mRas[$];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rstN) begin
      mBoot    = 1'b1;
      mPc      = RESET_VEC;
      mIdPc    = 16'h0000;
      mIdInstr = 16'h0000;
      mIdValid = 1'b0;
      mWaiting = 1'b0;
      mTimeout = 1'b0;
      mMiss    = 0;
      mRas.delete();
    end else begin
      if (mBoot) begin
        mBoot = 1'b0;
      end else if (flush) begin
        mIdValid = 1'b0;
        mIdInstr = 16'h0000;
        mPc      = nxtPc;
        mWaiting = 1'b0;
        mMiss    = 0;
      end else if (stall) begin
        mMiss = mMiss;
      end else if (ready) begin
        mIdInstr = memWord(mPc);
        mIdPc    = mPc;
        mIdValid = 1'b1;
        mPc      = nxtPc;
        mWaiting = 1'b0;
        mMiss    = 0;
      end else begin
        mIdValid = 1'b0;
        mIdInstr = 16'h0000;
        mWaiting = 1'b1;
        if (mMiss < WAIT_MAX) mMiss = mMiss + 1;
      end
      if (mMiss >= WAIT_MAX) mTimeout = 1'b1;
`ifdef FETCH_RAS_EN
      if (rasPush && rasPop && mRas.size() > 0) begin
        mRas[mRas.size()-1] = rasPushAddr;
      end else if (rasPush) begin
        mRas.push_back(rasPushAddr);
        if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
      end else if (rasPop && mRas.size() > 0) begin
        void'(mRas.pop_back());
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("if_pc", ifPc, mPc);
      checkOutput("imem_addr", imemBus.imem_addr, mPc);
      checkOutput("imem_req", 16'(imemBus.imem_req), 16'(!mBoot && (!stall || flush)));
      checkOutput("id_pc", idPc, mIdPc);
      checkOutput("id_instr", idInstr, mIdInstr);
      checkOutput("id_valid", 16'(idValid), 16'(mIdValid));
      checkOutput("fetch_wait", 16'(fetchWait), 16'(mWaiting));
      checkOutput("imem_timeout", 16'(imemTimeout), 16'(mTimeout));
`ifdef FETCH_RAS_EN
      checkOutput("ras_top", rasTop, (mRas.size() == 0) ? 16'h0000 : mRas[mRas.size()-1]);
      checkOutput("ras_empty", 16'(rasEmpty), 16'(mRas.size() == 0));
`else
      checkOutput("ras_top", rasTop, 16'h0000);
      checkOutput("ras_empty", 16'(rasEmpty), 16'h0001);
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic st, input logic fl, input logic rdy,
                               input logic [15:0] np, input logic psh, input logic [15:0] pa,
                               input logic pp);
    rstN        = r;
    stall       = st;
    flush       = fl;
    ready       = rdy;
    nxtPc       = np;
    rasPush     = psh;
    rasPushAddr = pa;
    rasPop      = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic fl, input logic rdy, input logic [15:0] np);
    applyStimulus(1'b1, st, fl, rdy, np, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic rasStep(input logic psh, input logic [15:0] pa, input logic pp);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, mPc + 16'd1, psh, pa, pp);
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; flush = 1'b0; ready = 1'b1;
    nxtPc = 16'h0000; rasPush = 1'b0; rasPop = 1'b0; rasPushAddr = 16'h0000;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    $display("[TB] reset state");
    checkOutput("rst if_pc", ifPc, 16'h0000);
    checkOutput("rst id_valid", 16'(idValid), 16'h0000);
    checkOutput("rst id_instr", idInstr, 16'h0000);
    checkOutput("rst id_pc", idPc, 16'h0000);
    checkOutput("rst imem_req", 16'(imemBus.imem_req), 16'h0000);
    checkOutput("rst fetch_wait", 16'(fetchWait), 16'h0000);
    checkOutput("rst imem_timeout", 16'(imemTimeout), 16'h0000);
    checkOutput("rst ras_top", rasTop, 16'h0000);
    checkOutput("rst ras_empty", 16'(rasEmpty), 16'h0001);

    $display("[TB] boot and sequential fetch");
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("boot imem_req", 16'(imemBus.imem_req), 16'h0001);
    checkOutput("boot id_valid", 16'(idValid), 16'h0000);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("seq0 id_pc", idPc, 16'h0000);
    checkOutput("seq0 id_instr", idInstr, 16'hC3A0);
    checkOutput("seq0 id_valid", 16'(idValid), 16'h0001);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("seq1 id_pc", idPc, 16'h0001);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("seq2 id_pc", idPc, 16'h0002);
    checkOutput("seq2 if_pc", ifPc, 16'h0003);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);

    $display("[TB] stall at pc 5");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'hDEAD);
    checkOutput("stall imem_req", 16'(imemBus.imem_req), 16'h0000);
    checkOutput("stall if_pc", ifPc, 16'h0005);
    checkOutput("stall id_pc", idPc, 16'h0004);
    checkOutput("stall id_instr", idInstr, 16'hC3A4);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("resume id_pc", idPc, 16'h0005);
    checkOutput("resume if_pc", ifPc, 16'h0006);

    $display("[TB] flush beats stall");
    step(1'b1, 1'b1, 1'b1, 16'h0040);
    checkOutput("flush id_valid", 16'(idValid), 16'h0000);
    checkOutput("flush id_instr", idInstr, 16'h0000);
    checkOutput("flush if_pc", ifPc, 16'h0040);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("post flush id_instr", idInstr, 16'hC3E0);

    $display("[TB] wait, flush clears counter, timeout");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("wait fetch_wait", 16'(fetchWait), 16'h0001);
    checkOutput("wait if_pc", ifPc, 16'h0041);
    step(1'b0, 1'b1, 1'b0, 16'h0080);
    checkOutput("wait flush fetch_wait", 16'(fetchWait), 16'h0000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 16'hBEEF);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("wait stall fetch_wait", 16'(fetchWait), 16'h0001);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("timeout at 14", 16'(imemTimeout), 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("timeout at 15", 16'(imemTimeout), 16'h0001);
    checkOutput("timeout id_valid", 16'(idValid), 16'h0000);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("after wait id_pc", idPc, 16'h0080);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("timeout sticky", 16'(imemTimeout), 16'h0001);

    $display("[TB] reset during wait");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    checkOutput("mid rst timeout", 16'(imemTimeout), 16'h0000);
    checkOutput("mid rst fetch_wait", 16'(fetchWait), 16'h0000);
    checkOutput("mid rst if_pc", ifPc, 16'h0000);
    checkOutput("mid rst imem_req", 16'(imemBus.imem_req), 16'h0000);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    step(1'b0, 1'b0, 1'b1, mPc + 16'd1);
    checkOutput("restart id_pc", idPc, 16'h0000);

    $display("[TB] return-address stack");
`ifdef FETCH_RAS_EN
    rasStep(1'b1, 16'h0010, 1'b0);
    rasStep(1'b1, 16'h0020, 1'b0);
    rasStep(1'b1, 16'h0030, 1'b0);
    rasStep(1'b1, 16'h0040, 1'b0);
    rasStep(1'b1, 16'h0050, 1'b0);
    checkOutput("ras top 50", rasTop, 16'h0050);
    checkOutput("ras not empty", 16'(rasEmpty), 16'h0000);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras pop 40", rasTop, 16'h0040);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras pop 30", rasTop, 16'h0030);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras pop 20", rasTop, 16'h0020);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras drained top", rasTop, 16'h0000);
    checkOutput("ras drained empty", 16'(rasEmpty), 16'h0001);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras pop empty", 16'(rasEmpty), 16'h0001);
    rasStep(1'b1, 16'h0010, 1'b0);
    rasStep(1'b1, 16'h0020, 1'b0);
    rasStep(1'b1, 16'h0030, 1'b0);
    rasStep(1'b1, 16'h0077, 1'b1);
    checkOutput("ras push+pop", rasTop, 16'h0077);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras after swap 20", rasTop, 16'h0020);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras after swap 10", rasTop, 16'h0010);
    rasStep(1'b0, 16'h0000, 1'b1);
    checkOutput("ras after swap empty", 16'(rasEmpty), 16'h0001);
`else
    rasStep(1'b1, 16'h0010, 1'b0);
    rasStep(1'b1, 16'h0020, 1'b1);
    checkOutput("no ras top", rasTop, 16'h0000);
    checkOutput("no ras empty", 16'(rasEmpty), 16'h0001);
`endif

    $display("[TB] mixed directed pattern");
    for (int i = 0; i < 40; i++) begin
      step((i % 5) == 3, (i % 7) == 4, (i % 3) != 1,
           ((i % 7) == 4) ? 16'h0100 + 16'(i * 4) : mPc + 16'd1);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It owns the architectural PC register and the IF/ID pipeline register, and it issues instruction-memory requests with a valid/ready handshake. It consumes the next-PC value chosen by the next-PC logic and applies data-hazard stalls and control-hazard flushes. An optional return-address stack supplies RET targets back to the next-PC logic.

## Interface
Parameters:
- RESET_VEC, 16'h0000, PC value loaded at reset.
- WAIT_MAX, 15, memory wait cycles tolerated before `imem_timeout` is raised.
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- nxt_pc  in  16  next PC from the next-PC logic.
- stall  in  1  data hazard; hold PC and IF/ID.
- flush  in  1  control hazard; bubble IF/ID and load `nxt_pc`.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; always equal to `if_pc`.
- imem_ready  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- imem_rdata  in  16  fetched instruction.
- if_pc  out  16  current PC, fed back to the next-PC logic.
- id_pc  out  16  PC of the instruction in ID.
- id_instr  out  16  instruction in ID.
- id_valid  out  1  ID holds a real instruction.
- fetch_wait  out  1  high while in WAIT.
- imem_timeout  out  1  sticky; set when the wait counter reaches WAIT_MAX.
- ras_push  in  1  a CALL is in EX.
- ras_push_addr  in  16  return address, which is the CALL PC + 2 because of the delay slot.
- ras_pop  in  1  a RET is in EX.
- ras_top  out  16  current top of the return-address stack.
- ras_empty  out  1  the return-address stack is empty.

## Operation
- FSM states: BOOT, RUN, WAIT.
- Reset, all outputs:
  - state = BOOT; pc = RESET_VEC.
  - id_valid = 0, id_instr = NOP, id_pc = 0.
  - imem_req = 0, fetch_wait = 0, imem_timeout = 0.
  - Return-address stack empty: ras_top = 0, ras_empty = 1.
- BOOT: imem_req = 0 for one cycle, then go to RUN.
- RUN and WAIT: imem_req = !stall || flush. Define fire = imem_req & imem_ready.
- Priority each cycle, highest first:
  1. flush: id_valid <= 0, id_instr <= NOP, pc <= nxt_pc, state <= RUN, wait counter cleared. Flush wins over stall.
  2. stall: pc, IF/ID and state hold; the wait counter holds.
  3. fire: id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1, pc <= nxt_pc, state <= RUN, wait counter cleared.
  4. Otherwise (request not accepted): id_valid <= 0, id_instr <= NOP, pc holds, state <= WAIT, wait counter increments.
- The wait counter saturates at WAIT_MAX. Reaching WAIT_MAX sets imem_timeout, which stays set until reset.
- The next-PC logic asserts flush whenever it redirects. In any non-flush cycle without fire, `nxt_pc` is ignored.
- Reset asserted mid-operation overrides everything on that edge, including an outstanding WAIT.
- All PC arithmetic lives upstream. This block only stores 16-bit values, so no overflow handling is needed here.

## Timing
- Fetch latency: instruction accepted at edge N appears on id_instr/id_valid after edge N.
- Throughput is one instruction per cycle while imem_ready = 1 and there is no stall.
- if_pc changes only on fire or flush.
- The first request is issued in the cycle after BOOT, i.e. two edges after rst_n rises.
- Return-address stack updates happen on the edge; ras_top and ras_empty are registered.

## Configuration
- `FETCH_RAS_EN` defined: the return-address stack is built.
  - Push writes ras_push_addr at the top.
  - Pop removes the top; ras_top then shows the new top.
  - Push with a full stack overwrites the oldest entry; the count stays at RAS_DEPTH.
  - Pop with an empty stack is ignored; ras_top stays 0.
  - Simultaneous push and pop: the top entry is replaced by ras_push_addr and the count is unchanged.
- `FETCH_RAS_EN` undefined: ras_push and ras_pop are ignored; ras_top = 0 and ras_empty = 1 constantly.

## Structure
- Shared package `cpu_pkg`: NOP encoding (16'h0000), the default RESET_VEC, and the fetch FSM state enum.
- One sub-module, `ret_addr_stack`: circular buffer with a pointer and a count, instantiated only under FETCH_RAS_EN.

## Test plan
- Reset then release with imem_ready = 1 and nxt_pc = if_pc + 1 → BOOT for one cycle, then id_pc = 0, 1, 2 on consecutive cycles with id_valid = 1.
- stall held 3 cycles at if_pc = 5 → imem_req = 0; if_pc, id_pc and id_instr unchanged; fetching resumes at 5.
- flush and stall together with nxt_pc = 16'h0040 → id_valid = 0, id_instr = NOP; next if_pc = 16'h0040.
- imem_ready held low for WAIT_MAX cycles → fetch_wait = 1, id_valid = 0 each cycle, imem_timeout = 1 and sticky until rst_n = 0.
- FETCH_RAS_EN with depth 4: push 16'h0010, 20, 30, 40, 50, then pop 4 times → ras_top shows 50, 40, 30, 20, then ras_empty = 1 (the oldest entry, 10, was overwritten).
- Simultaneous push of 16'h0077 and pop with ras_top = 16'h0030 → ras_top = 16'h0077, count unchanged.
